// File: rtl/data_mem_stage.sv
// data_mem_stage: MEM stage of the pipelined MIPS core.
// Byte-addressed data memory with sub-word loads/stores, misalignment
// detection, a programmable wait-state stall, and the MEM/WB register.
module data_mem_stage #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1,
  parameter int REG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [31:0]      ex_alu_out,
  input  logic [31:0]      ex_store_data,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [1:0]       ex_size,
  input  logic             ex_unsigned,
  input  logic             ex_reg_write,
  input  logic             ex_wb_sel,
  output logic             stall,
  output logic             wb_valid,
  output logic [31:0]      wb_alu_out,
  output logic [31:0]      wb_read_data,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_reg_write,
  output logic             wb_wb_sel,
  output logic             wb_misalign
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic       HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [2:0] CNT_INIT = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        off;
  logic [ADDR_W-1:0] widx;
  logic              mem_op, aligned, misalign, access;
  logic              stall_raw, commit, mem_we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rd_word;
  logic [31:0]       words [DEPTH];

  logic             wb_valid_q, wb_reg_write_q, wb_wb_sel_q, wb_misalign_q;
  logic [31:0]      wb_alu_out_q, wb_read_data_q;
  logic [REG_W-1:0] wb_dest_q;

  // Right-align the addressed byte/half and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] o,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> {o, 3'b000};
    case (size)
      2'b00:   return {{24{sh[7] & ~uns}}, sh[7:0]};
      2'b01:   return {{16{sh[15] & ~uns}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  assign off      = ex_alu_out[1:0];
  assign widx     = ex_alu_out[ADDR_W+1:2];
  assign mem_op   = ex_valid & (ex_mem_read | ex_mem_write);
  assign aligned  = (ex_size == 2'b00) | ((ex_size == 2'b01) & ~off[0]) | (off == 2'b00);
  assign misalign = mem_op & ~aligned;
  assign access   = mem_op & aligned;

  // The stall is forced low while reset is held so a reset during WAIT
  // releases upstream at once; the same gate keeps a pending store from
  // committing while in reset.
  assign stall_raw = HAS_WAIT & (((state_q == IDLE) & access) |
                                 ((state_q == WAIT) & (cnt_q != 3'd0)));
  assign stall     = rst_n & stall_raw;
  assign commit    = rst_n & access & ~stall_raw;
  assign mem_we    = commit & ex_mem_write;

  // Lane enables and lane-replicated store data for SB/SH/SW.
  always_comb begin
    be    = 4'b1111;
    wdata = ex_store_data;
    case (ex_size)
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Memory words power up holding their own index and ignore reset.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] word_q = 32'(i);
    // Lane-masked write of this word on the completion edge of a store.
    always_ff @(posedge clk) begin
      if (mem_we && (widx == ADDR_W'(i))) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) word_q[8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
    assign words[i] = word_q;
  end

  // Pre-write contents give read-before-write when load and store coincide.
  assign rd_word = words[widx];

  // Wait-state FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: enter WAIT on a new access, count down, leave at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (access && HAS_WAIT) begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
    end else begin
      if (cnt_q == 3'd0) state_d = IDLE;
      else               cnt_d   = cnt_q - 3'd1;
    end
  end

  // MEM/WB register: bubble on stalled edges, load otherwise; read data only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_wb_sel_q    <= 1'b0;
      wb_misalign_q  <= 1'b0;
      wb_alu_out_q   <= 32'd0;
      wb_read_data_q <= 32'd0;
      wb_dest_q      <= '0;
    end else if (stall_raw) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
    end else begin
      wb_valid_q     <= ex_valid;
      wb_reg_write_q <= ex_reg_write & ~misalign;
      wb_wb_sel_q    <= ex_wb_sel;
      wb_misalign_q  <= misalign;
      wb_alu_out_q   <= ex_alu_out;
      wb_dest_q      <= ex_dest;
      if (commit) wb_read_data_q <= load_ext(rd_word, off, ex_size, ex_unsigned);
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_wb_sel    = wb_wb_sel_q;
  assign wb_misalign  = wb_misalign_q;
  assign wb_alu_out   = wb_alu_out_q;
  assign wb_read_data = wb_read_data_q;
  assign wb_dest      = wb_dest_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: three instances (1, 3 and 0 wait states)
// driven from a directed vector table, a reset-during-wait sequence and
// random traffic, all checked against a word-array reference model.
`timescale 1ns/1ps
module tb_data_mem_stage;
  localparam int N     = 3;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic        rw;
    logic        sel;
  } op_t;

  typedef struct {
    int          dut;
    op_t         op;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_s  [N];
  op_t         in_s   [N];
  logic        stall_s[N], wbv[N], wbrw[N], wbsel[N], wbmis[N];
  logic [31:0] wbalu[N], wbrd[N];
  logic [4:0]  wbdest[N];

  int errors = 0;
  int checks = 0;
  int last_d = -1;

  logic [31:0] mdl_mem [N][DEPTH];
  logic        e_valid[N], e_rw[N], e_sel[N], e_mis[N];
  logic [31:0] e_alu[N], e_rd[N];
  logic [4:0]  e_dest[N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_stage #(
      .ADDR_W(10), .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 3 : 0)), .REG_W(5)
    ) dut (
      .clk(clk), .rst_n(rst_s[g]),
      .ex_valid(in_s[g].valid), .ex_alu_out(in_s[g].alu), .ex_store_data(in_s[g].sd),
      .ex_dest(in_s[g].dest), .ex_mem_read(in_s[g].rd), .ex_mem_write(in_s[g].wr),
      .ex_size(in_s[g].size), .ex_unsigned(in_s[g].uns), .ex_reg_write(in_s[g].rw),
      .ex_wb_sel(in_s[g].sel), .stall(stall_s[g]), .wb_valid(wbv[g]),
      .wb_alu_out(wbalu[g]), .wb_read_data(wbrd[g]), .wb_dest(wbdest[g]),
      .wb_reg_write(wbrw[g]), .wb_wb_sel(wbsel[g]), .wb_misalign(wbmis[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  function automatic op_t ld(input logic [31:0] a, input logic [1:0] sz, input logic u);
    op_t o = '0;
    o.valid = 1; o.alu = a; o.rd = 1; o.size = sz; o.uns = u; o.rw = 1; o.sel = 1; o.dest = 5'd7;
    return o;
  endfunction

  function automatic op_t st(input logic [31:0] a, input logic [31:0] dat, input logic [1:0] sz);
    op_t o = '0;
    o.valid = 1; o.alu = a; o.sd = dat; o.wr = 1; o.size = sz;
    return o;
  endfunction

  function automatic op_t aluop(input logic [31:0] a, input logic [4:0] dst);
    op_t o = '0;
    o.valid = 1; o.alu = a; o.dest = dst; o.rw = 1;
    return o;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %h expected %h", name, d, act, exp);
    end
  endtask

  task automatic clear_exp(input int d, input logic with_rd);
    e_valid[d] = 0; e_rw[d] = 0; e_sel[d] = 0; e_mis[d] = 0; e_alu[d] = 0; e_dest[d] = 0;
    if (with_rd) e_rd[d] = 0;
  endtask

  task automatic chk_wb(input int d);
    chk("wb_valid", d, wbv[d], e_valid[d]);
    chk("wb_alu_out", d, wbalu[d], e_alu[d]);
    chk("wb_read_data", d, wbrd[d], e_rd[d]);
    chk("wb_dest", d, wbdest[d], e_dest[d]);
    chk("wb_reg_write", d, wbrw[d], e_rw[d]);
    chk("wb_wb_sel", d, wbsel[d], e_sel[d]);
    chk("wb_misalign", d, wbmis[d], e_mis[d]);
  endtask

  // Present one instruction, follow its stall cycles, check MEM/WB after completion.
  task automatic run(input int d, input op_t op, output int n);
    int          idx, off, nb, base, exp_st;
    logic        aligned, memop, acc;
    logic [31:0] old, val, mask, nw;
    if (last_d != d) clear_exp(d, 1'b0);
    last_d = d;
    in_s[d] = op;
    #1;
    idx  = int'(op.alu >> 2) % DEPTH;
    off  = int'(op.alu % 4);
    nb   = (op.size == 2'b00) ? 1 : ((op.size == 2'b01) ? 2 : 4);
    aligned = (nb == 1) || (nb == 2 && off % 2 == 0) || (off == 0);
    memop = op.valid && (op.rd || op.wr);
    acc   = memop && aligned;
    exp_st = acc ? ws_of(d) : 0;
    n = 0;
    while (stall_s[d] === 1'b1 && n < 12) begin
      @(posedge clk); #1;
      n++;
      chk("bubble_valid", d, wbv[d], 0);
      chk("bubble_reg_write", d, wbrw[d], 0);
      chk("bubble_alu_hold", d, wbalu[d], e_alu[d]);
    end
    chk("stall_cycles", d, n, exp_st);
    if (acc) begin
      old  = mdl_mem[d][idx];
      base = (nb == 4) ? 0 : off;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
      val  = (old >> (8 * base)) & mask;
      if (!op.uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
      e_rd[d] = val;
      if (op.wr) begin
        nw = old;
        for (int b = 0; b < nb; b++) nw[8*(base+b) +: 8] = op.sd[8*b +: 8];
        mdl_mem[d][idx] = nw;
      end
    end
    e_valid[d] = op.valid;
    e_alu[d]   = op.alu;
    e_dest[d]  = op.dest;
    e_sel[d]   = op.sel;
    e_mis[d]   = memop && !aligned;
    e_rw[d]    = op.rw && !e_mis[d];
    @(posedge clk); #1;
    chk_wb(d);
    in_s[d] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   n;
    op_t  o;

    for (int d = 0; d < N; d++) begin
      rst_s[d] = 1'b0;
      in_s[d]  = '0;
      clear_exp(d, 1'b1);
      for (int i = 0; i < DEPTH; i++) mdl_mem[d][i] = 32'(i);
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      chk("reset_stall", d, stall_s[d], 0);
      chk_wb(d);
    end
    for (int d = 0; d < N; d++) rst_s[d] = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    tbl.push_back('{0, aluop(32'h1234, 5'd3),          0, 0, 0});
    tbl.push_back('{0, ld(32'h14, 2'b10, 0),           1, 32'h5, 1});
    tbl.push_back('{0, st(32'h21, 32'hAB, 2'b00),      0, 0, 1});
    tbl.push_back('{0, ld(32'h21, 2'b00, 0),           1, 32'hFFFF_FFAB, 1});
    tbl.push_back('{0, ld(32'h21, 2'b00, 1),           1, 32'h0000_00AB, 1});
    tbl.push_back('{0, ld(32'h20, 2'b10, 0),           1, 32'h0000_AB08, 1});
    tbl.push_back('{0, st(32'h2A, 32'h8001, 2'b01),    0, 0, 1});
    tbl.push_back('{0, ld(32'h2A, 2'b01, 0),           1, 32'hFFFF_8001, 1});
    tbl.push_back('{0, ld(32'h28, 2'b10, 0),           1, 32'h8001_000A, 1});
    tbl.push_back('{0, ld(32'h06, 2'b10, 0),           0, 0, 0});
    tbl.push_back('{0, st(32'h03, 32'h1234, 2'b01),    0, 0, 0});
    tbl.push_back('{0, ld(32'h04, 2'b10, 0),           1, 32'h1, 1});
    tbl.push_back('{0, ld(32'h00, 2'b10, 0),           1, 32'h0, 1});
    o = ld(32'h30, 2'b10, 0); o.wr = 1; o.sd = 32'h55;
    tbl.push_back('{0, o,                              1, 32'hC, 1});
    tbl.push_back('{0, ld(32'h30, 2'b10, 0),           1, 32'h55, 1});
    tbl.push_back('{0, ld(32'h2A, 2'b01, 1),           1, 32'h0000_8001, 1});
    tbl.push_back('{0, ld(32'h1040, 2'b10, 0),         1, 32'h10, 1});
    tbl.push_back('{2, ld(32'h14, 2'b10, 0),           1, 32'h5, 0});
    tbl.push_back('{2, st(32'h08, 32'hCAFE_F00D, 2'b11), 0, 0, 0});
    tbl.push_back('{2, ld(32'h08, 2'b10, 0),           1, 32'hCAFE_F00D, 0});
    tbl.push_back('{2, ld(32'h0B, 2'b00, 0),           1, 32'hFFFF_FFCA, 0});
    tbl.push_back('{1, ld(32'h44, 2'b10, 0),           1, 32'h11, 3});
    tbl.push_back('{1, ld(32'h48, 2'b10, 0),           1, 32'h12, 3});
    foreach (tbl[i]) begin
      run(tbl[i].dut, tbl[i].op, n);
      chk($sformatf("tbl%0d_stall", i), tbl[i].dut, n, tbl[i].exp_st);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), tbl[i].dut, wbrd[tbl[i].dut], tbl[i].exp_rd);
    end

    // Reset in the second stall cycle of a 3-wait-state SW: store is dropped.
    if (last_d != 1) clear_exp(1, 1'b0);
    last_d = 1;
    in_s[1] = st(32'h1040, 32'hDEAD, 2'b10);
    #1;
    chk("rst_seq_stall1", 1, stall_s[1], 1);
    @(posedge clk); #1;
    chk("rst_seq_stall2", 1, stall_s[1], 1);
    rst_s[1] = 1'b0;
    #1;
    chk("rst_seq_stall_drop", 1, stall_s[1], 0);
    in_s[1] = '0;
    @(posedge clk); #1;
    rst_s[1] = 1'b1;
    clear_exp(1, 1'b1);
    chk_wb(1);
    run(1, ld(32'h40, 2'b10, 0), n);
    chk("rst_seq_word16", 1, wbrd[1], 32'h10);

    // Random traffic against the model.
    for (int it = 0; it < 300; it++) begin
      int d;
      d = $urandom_range(0, N - 1);
      o = '0;
      o.valid = ($urandom_range(0, 9) != 0);
      o.alu   = ($urandom << 12) | 32'($urandom_range(0, 255));
      o.sd    = $urandom;
      o.dest  = 5'($urandom);
      o.rd    = 1'($urandom);
      o.wr    = 1'($urandom);
      o.size  = 2'($urandom);
      o.uns   = 1'($urandom);
      o.rw    = 1'($urandom);
      o.sel   = 1'($urandom);
      run(d, o, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

Parametrised MEM stage of the pipelined MIPS core: byte-addressed data memory plus the MEM/WB pipeline register. It adds sub-word loads and stores (byte and halfword, signed and unsigned), misalignment detection, and a programmable wait-state count that stalls the pipeline. It sits between the EX/MEM register and write-back, and drives the stall line back to the hazard unit.

## Interface
Parameters:
- ADDR_W, 10, word-address width; memory depth is 2^ADDR_W 32-bit words
- WAIT_STATES, 1, extra cycles per memory access, legal range 0..7
- REG_W, 5, destination register index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM slot holds a real instruction
- ex_alu_out  in  32  byte address for memory ops; result for ALU ops
- ex_store_data  in  32  store data, already forwarded
- ex_dest  in  REG_W  write-back destination (Rt/Rd)
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- ex_unsigned  in  1  zero-extend loads (LBU/LHU)
- ex_reg_write  in  1  write-back enable
- ex_wb_sel  in  1  write-back source: 1 = memory, 0 = ALU
- stall  out  1  hold EX/MEM and upstream stages
- wb_valid  out  1  MEM/WB slot valid
- wb_alu_out  out  32  registered ex_alu_out
- wb_read_data  out  32  extended load data
- wb_dest  out  REG_W  registered destination
- wb_reg_write  out  1  registered write enable, gated by misalignment
- wb_wb_sel  out  1  registered write-back source
- wb_misalign  out  1  misaligned-access flag for the instruction in MEM/WB

## Operation
- Access: ex_valid, and ex_mem_read or ex_mem_write, and aligned.
- Alignment rules:
  - Byte accesses are always aligned.
  - Half is misaligned when addr[0] = 1.
  - Word is misaligned when addr[1:0] != 0.
- Word index is addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the depth.
- Lanes are little-endian: lane k = bits 8k+7:8k, and byte offset k selects lane k.
- Stores:
  - SB writes only lane addr[1:0], using ex_store_data[7:0].
  - SH writes lanes addr[1]*2 and addr[1]*2+1, using ex_store_data[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Loads: the selected byte or half is right-aligned, then sign-extended, or zero-extended when ex_unsigned = 1.
- Read and write both set: the write is performed, and wb_read_data returns the word's pre-write contents (read-before-write).
- Misaligned access:
  - No memory read or write takes place.
  - No stall.
  - MEM/WB loads normally, except wb_reg_write = 0 and wb_misalign = 1.
- Non-access instructions and bubbles pass through in one cycle with no stall.
- FSM states:
  - IDLE → WAIT when an access is present and WAIT_STATES > 0; the counter loads WAIT_STATES-1.
  - WAIT decrements the counter each cycle and returns to IDLE on the edge where the counter is 0.
- stall = (IDLE and access and WAIT_STATES > 0) or (WAIT and counter != 0). It is combinational.
- Completion edge: the first rising edge with stall = 0 while the access is present. On this edge only:
  - the memory write is committed;
  - the read data is captured;
  - MEM/WB loads.
- On every edge with stall = 1, MEM/WB loads a bubble: wb_valid = 0 and wb_reg_write = 0. The other wb_* fields hold their values.
- Upstream holds ex_* stable while stall = 1. The block does not latch ex_* itself.
- Memory array contents are not affected by rst_n. At simulation start, word i is initialised to i for every i.

## Timing
- Reset values (async assert, sync release):
  - FSM = IDLE, counter = 0, stall = 0;
  - wb_valid, wb_reg_write, wb_wb_sel and wb_misalign = 0;
  - wb_alu_out and wb_read_data = 0, wb_dest = 0.
- Latency per instruction:
  - 1 cycle for non-access or misaligned instructions;
  - WAIT_STATES+1 cycles for an access, with stall high for the first WAIT_STATES of those cycles.
- With WAIT_STATES = 0, stall is tied low and every instruction takes 1 cycle.
- Back-to-back accesses: the cycle after a completion edge, the next access stalls again. There is no pipelining of accesses.
- Reset asserted during WAIT: the pending store is discarded (memory unchanged), the FSM returns to IDLE, and stall drops immediately.
- A store and a following load to the same word: the load, completing later, sees the stored data.

## Test plan
- Reset then idle: all wb_* = 0 and stall = 0. Drive an ALU op with ex_alu_out = 0x1234, ex_dest = 3 → next edge gives wb_alu_out = 0x1234, wb_dest = 3, wb_valid = 1, no stall.
- WAIT_STATES = 1, LW from address 0x14 → stall high for 1 cycle, then wb_read_data = 5 and wb_wb_sel = 1. The intervening MEM/WB slot is a bubble (wb_valid = 0).
- SB of 0xAB to 0x21, then LB 0x21 and LBU 0x21 → memory word 8 = 0x0000AB08. LB returns 0xFFFFFFAB; LBU returns 0x000000AB.
- SH of 0x8001 to 0x2A, then LH 0x2A → word 10 = 0x8001000A, LH = 0xFFFF8001.
- LW at 0x06 and SH at 0x03 → no stall, wb_misalign = 1, wb_reg_write = 0, words 1 and 0 unchanged.
- WAIT_STATES = 3: SW 0xDEAD to 0x40 with rst_n pulsed low in the second stall cycle → stall drops at once and word 16 still reads 16. Address 0x1000 + 0x40 with ADDR_W = 10 wraps to word 16.
